// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU.
//   Single-cycle ops: AND, XOR, OR, ADD/ADDI, SUB, SLL, SRL, SRA, SLT.
//   Iterative ops:    MUL (shift-add) and DIV/REM (restoring division).
//                     Each works on operand magnitudes, takes WIDTH cycles and
//                     applies the sign at the end.
//   Results and flags are registered.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i / ready_o   request handshake; ready_o is low while an iterative op runs
//   ALUCtrl_i           4-bit opcode
//   data1_i, data2_i    signed operands (shift amount is data2_i[SHAMT_W-1:0])
//   valid_o             one-cycle pulse when a new result is written
//   data_o, Zero_o      result and (result == 0)
//   divzero_o           last result came from DIV/REM with a zero divisor
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             divzero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND = 4'b0000, OP_XOR = 4'b0001, OP_SLL = 4'b0010,
                         OP_ADD = 4'b0011, OP_SUB = 4'b0100, OP_MUL = 4'b0101,
                         OP_ADDI = 4'b0110, OP_SRA = 4'b0111, OP_DIV = 4'b1000,
                         OP_REM = 4'b1001, OP_SRL = 4'b1010, OP_OR = 4'b1011,
                         OP_SLT = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;   // MUL: shifting multiplicand; DIV: dividend / quotient
  logic [WIDTH-1:0] op_b;   // MUL: shifting multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc;    // MUL: partial product;       DIV: partial remainder
  logic             neg;    // negate the final magnitude
  logic             is_rem;
  logic             divz;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   a_abs, b_abs, single_res;
  logic [WIDTH-1:0]   mul_acc_nxt, rem_nxt, quo_nxt;
  logic [WIDTH:0]     trial, diff;
  logic               fits;
  logic               res_load, res_dz;
  logic [WIDTH-1:0]   res_val;

  assign accept = valid_i && ready_o;
  assign shamt  = data2_i[SHAMT_W-1:0];
  assign a_abs  = data1_i[WIDTH-1] ? -data1_i : data1_i;
  assign b_abs  = data2_i[WIDTH-1] ? -data2_i : data2_i;

  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      OP_AND:         single_res = data1_i & data2_i;
      OP_XOR:         single_res = data1_i ^ data2_i;
      OP_OR:          single_res = data1_i | data2_i;
      OP_ADD, OP_ADDI: single_res = data1_i + data2_i;
      OP_SUB:         single_res = data1_i - data2_i;
      OP_SLL:         single_res = data1_i << shamt;
      OP_SRL:         single_res = data1_i >> shamt;
      OP_SRA:         single_res = $signed(data1_i) >>> shamt;
      OP_SLT:         single_res = {{(WIDTH-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
      default:        single_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step. The last step of an
  // iterative op is written straight into data_o, so the result lands on the
  // WIDTH-th edge after accept.
  assign mul_acc_nxt = op_b[0] ? acc + op_a : acc;
  assign trial       = {acc, op_a[WIDTH-1]};
  assign diff        = trial - {1'b0, op_b};
  assign fits        = !diff[WIDTH];
  assign rem_nxt     = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt     = {op_a[WIDTH-2:0], fits};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = (state == S_IDLE);
    res_load  = 1'b0;
    res_val   = '0;
    res_dz    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (ALUCtrl_i)
            OP_MUL:         state_nxt = S_MUL;
            OP_DIV, OP_REM: state_nxt = S_DIV;
            default: begin
              res_load = 1'b1;
              res_val  = single_res;
            end
          endcase
        end
      end
      S_MUL: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          res_load  = 1'b1;
          res_val   = neg ? -mul_acc_nxt : mul_acc_nxt;
        end
      end
      S_DIV: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          res_load  = 1'b1;
          res_dz    = divz;
          if (is_rem) res_val = neg ? -rem_nxt : rem_nxt;
          else        res_val = neg ? -quo_nxt : quo_nxt;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      data_o    <= '0;
      Zero_o    <= 1'b1;
      divzero_o <= 1'b0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      is_rem    <= 1'b0;
      divz      <= 1'b0;
    end else begin
      valid_o <= res_load;
      if (res_load) begin
        data_o    <= res_val;
        Zero_o    <= (res_val == '0);
        divzero_o <= res_dz;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt    <= CNT_W'(WIDTH - 1);
            op_a   <= a_abs;
            op_b   <= b_abs;
            acc    <= '0;
            is_rem <= (ALUCtrl_i == OP_REM);
            divz   <= (data2_i == '0);
            // Zero divisor: quotient stays all ones (no sign fix), remainder
            // is |A| re-signed by A, i.e. A itself.
            case (ALUCtrl_i)
              OP_REM:  neg <= data1_i[WIDTH-1];
              OP_DIV:  neg <= (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]) && (data2_i != '0);
              default: neg <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
            endcase
          end
        end
        S_MUL: begin
          acc  <= mul_acc_nxt;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          cnt  <= cnt - 1'b1;
        end
        S_DIV: begin
          acc  <= rem_nxt;
          op_a <= quo_nxt;
          cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
